// File: rtl/data_ram_sync.sv
// rtl/data_ram_sync.sv - single-clock data RAM with registered read port and clear sequencer
// Optional feature macro: DATA_RAM_PARITY_EN (per-word even parity with error injection)
module data_ram_sync #(
  parameter int          DATA_WIDTH = 8,
  parameter int          ADDR_WIDTH = 4,
  parameter int unsigned INIT_VALUE = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_req,
  output logic                  busy,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] wr_address,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  read_enable,
  input  logic [ADDR_WIDTH-1:0] rd_address,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  input  logic                  parity_inject,
  output logic                  parity_error
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [DATA_WIDTH-1:0] INIT_WORD = DATA_WIDTH'(INIT_VALUE);

`ifdef DATA_RAM_PARITY_EN
  localparam int WORD_W = DATA_WIDTH + 1;
`else
  localparam int WORD_W = DATA_WIDTH;
`endif

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  parity_error_q, parity_error_d;

  logic [WORD_W-1:0]     mem_q [DEPTH];

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WORD_W-1:0]     mem_wdata;

  logic [WORD_W-1:0]     wr_word;
  logic [WORD_W-1:0]     init_word;
  logic [WORD_W-1:0]     rd_word;
  logic                  fwd_hit;
  logic                  rd_mismatch;

`ifdef DATA_RAM_PARITY_EN
  // Stored parity is even parity of the data, optionally flipped to exercise the checker
  assign wr_word     = {(^data_in) ^ parity_inject, data_in};
  assign init_word   = {^INIT_WORD, INIT_WORD};
`else
  logic unused_parity_inject;
  assign unused_parity_inject = parity_inject;
  assign wr_word     = data_in;
  assign init_word   = INIT_WORD;
`endif

  // Same-address write bypasses the array so the read sees the word being written
  assign fwd_hit = write_enable && (wr_address == rd_address);
  assign rd_word = fwd_hit ? wr_word : mem_q[rd_address];

`ifdef DATA_RAM_PARITY_EN
  assign rd_mismatch = rd_word[DATA_WIDTH] ^ (^rd_word[DATA_WIDTH-1:0]);
`else
  assign rd_mismatch = 1'b0;
`endif

  // Next-state, array write port and read-port outputs
  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    busy_d         = busy_q;
    data_out_d     = data_out_q;
    rd_valid_d     = 1'b0;
    parity_error_d = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = wr_address;
    mem_wdata      = wr_word;

    case (state_q)
      ST_CLEAR: begin
        // Sweep every word with the init value; user accesses are ignored here
        mem_we    = 1'b1;
        mem_addr  = count_q;
        mem_wdata = init_word;
        count_d   = count_q + ADDR_WIDTH'(1);
        if (count_q == '1) begin
          state_d = ST_READY;
          busy_d  = 1'b0;
        end
      end
      ST_READY: begin
        if (clear_req) begin
          // Clear request wins; any same-cycle access is dropped
          state_d = ST_CLEAR;
          count_d = '0;
          busy_d  = 1'b1;
        end else begin
          mem_we = write_enable;
          if (read_enable) begin
            data_out_d     = rd_word[DATA_WIDTH-1:0];
            rd_valid_d     = 1'b1;
            parity_error_d = rd_mismatch;
          end
        end
      end
      default: begin
        state_d = ST_CLEAR;
        count_d = '0;
        busy_d  = 1'b1;
      end
    endcase
  end

  // Control and output registers; reset restarts the clear from word 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_CLEAR;
      count_q        <= '0;
      busy_q         <= 1'b1;
      data_out_q     <= '0;
      rd_valid_q     <= 1'b0;
      parity_error_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      busy_q         <= busy_d;
      data_out_q     <= data_out_d;
      rd_valid_q     <= rd_valid_d;
      parity_error_q <= parity_error_d;
    end
  end

  // Storage array; contents are defined by the clear sweep, not by reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_addr] <= mem_wdata;
    end
  end

  assign busy         = busy_q;
  assign data_out     = data_out_q;
  assign rd_valid     = rd_valid_q;
  assign parity_error = parity_error_q;

endmodule

// File: doc/data_ram_sync.md
# data_ram_sync

Parametrised successor to the team's 16x8 data RAM: a single-clock synchronous data memory with configurable word width and depth, a separate read port with registered output, and a built-in clear sequencer that fills every word with a known value after reset or on request. It is the CPU's data-memory slot, between the load/store path and the register file. The memory contents are always defined, and reads return a qualified `rd_valid` strobe.

## Interface
- `DATA_WIDTH`, default 8: word width in bits.
- `ADDR_WIDTH`, default 4: address width; depth = 2**ADDR_WIDTH words.
- `INIT_VALUE`, default 0: value written to every word by the clear sequencer; truncated to DATA_WIDTH.

- `clk`  in  1  clock. All state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `clear_req`  in  1  single-cycle request to re-run the clear sequence.
- `busy`  out  1  high while the clear sequence runs; accesses are ignored.
- `write_enable`  in  1  write strobe.
- `wr_address`  in  ADDR_WIDTH  write address.
- `data_in`  in  DATA_WIDTH  write data.
- `read_enable`  in  1  read strobe.
- `rd_address`  in  ADDR_WIDTH  read address.
- `data_out`  out  DATA_WIDTH  registered read data; holds its value between reads.
- `rd_valid`  out  1  one-cycle pulse marking new data on `data_out`.
- `parity_inject`  in  1  when high with a write, inverts the stored parity bit. Ignored unless parity is compiled in.
- `parity_error`  out  1  asserted together with `rd_valid` on a parity mismatch. Constant 0 unless parity is compiled in.

## Operation
- The design has two states: CLEAR and READY. A clear counter of ADDR_WIDTH bits is used only in CLEAR.
- On `reset` assertion, without waiting for a clock edge:
  - state becomes CLEAR and the counter is set to 0;
  - `busy`=1, `data_out`=0, `rd_valid`=0, `parity_error`=0.
- CLEAR state:
  - each edge writes INIT_VALUE, with correct parity, to mem[counter], then increments the counter;
  - on the edge that writes word 2**ADDR_WIDTH-1, the counter wraps to 0 and the state moves to READY;
  - `write_enable`, `read_enable` and `clear_req` are ignored; `rd_valid` stays 0.
- READY state, `clear_req`=1: the state moves to CLEAR with the counter at 0. Any write or read in the same cycle is dropped.
- READY state, `write_enable`=1: mem[wr_address] <= data_in on the edge.
- READY state, `read_enable`=1: `data_out` <= mem[rd_address] and `rd_valid` <= 1 on the edge. Otherwise `rd_valid` <= 0 and `data_out` holds.
- Read and write to the same address in the same cycle: the read returns the new `data_in` (write-first).
- Read and write to different addresses proceed independently.
- Address arithmetic wraps modulo depth. There is no out-of-range case.
- `reset` asserted mid-clear or mid-read restarts the clear from word 0. Partial contents are not preserved.

## Timing
- Read latency: 1 cycle. `read_enable` sampled at edge N gives `data_out` and `rd_valid` valid after edge N, with `rd_valid` low after edge N+1 unless another read is issued.
- Back-to-back reads every cycle are allowed; `rd_valid` stays high.
- Write latency: 1 cycle. Data written at edge N is readable by a read sampled at edge N, through write-first forwarding.
- Clear duration: exactly 2**ADDR_WIDTH edges after `reset` deasserts, or after the edge that samples `clear_req`. `busy` falls after the last clear edge. The first access is accepted at the following edge.
- `busy` is registered and glitch-free.

## Configuration
- `DATA_RAM_PARITY_EN` defined:
  - each word stores DATA_WIDTH+1 bits, the extra bit being even parity of the data;
  - a write with `parity_inject`=1 stores the inverted parity bit;
  - on a read, `parity_error` is the registered parity mismatch, valid only while `rd_valid`=1 and 0 otherwise;
  - forwarded write-first reads check the parity of the forwarded word, including the inject bit.
- `DATA_RAM_PARITY_EN` undefined: no parity storage, `parity_inject` is unused, `parity_error` is tied to 0. The port list is identical in both builds.

## Test plan
- Reset clear: pulse `reset`, then hold. Expect `busy`=1 for exactly 16 edges, then 0. Read addresses 0–15 and expect each `data_out`=0x00 with `rd_valid`=1 and `parity_error`=0.
- Write/readback: write 0xFF@1, 0xAA@2, 0xF0@3, then read 1, 2, 3 back-to-back. Expect 0xFF, 0xAA, 0xF0 on consecutive cycles with `rd_valid` high for 3 cycles.
- Write-first: write 0x5A@7 and read address 7 in the same cycle. Expect `data_out`=0x5A one cycle later.
- Clear request: after the writes above, pulse `clear_req` together with a write of 0x11@4. Expect `busy` high for 16 cycles, then a read of address 4 returns 0x00 and a read of address 1 returns 0x00.
- Reset mid-clear: assert `reset` 5 cycles into a clear. Expect `data_out`=0 and `rd_valid`=0 immediately, then a full 16-cycle clear.
- Parity (macro defined): write 0x3C@9 with `parity_inject`=1, then read address 9. Expect `data_out`=0x3C with `parity_error`=1. Re-write 0x3C@9 without inject and read again; expect `parity_error`=0.
